alu_port_arbiter: RTL and testbench
===================================

# alu_port_arbiter

Two-requester round-robin arbiter and sequencer for the shared ALU in the RISC datapath. Drives the select of the 2:1 operand/function muxes feeding the ALU and runs each granted operation for a fixed ALU latency. Captures the ALU result and returns it to the winner with a one-cycle done pulse. Sits between the two issue sources (main pipeline port 0, address/branch port 1) and the ALU.

## Interface

Parameters:
- WIDTH, 32, operand/result width
- LAT, 2, ALU result latency in cycles; legal range 1..16

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  request per port; held high until done for that port
- a0, b0  in  WIDTH  port 0 operands
- a1, b1  in  WIDTH  port 1 operands
- fn0, fn1  in  4  port 0/1 ALU function code
- sel  out  1  mux select; 0 = port 0, 1 = port 1 (registered)
- alu_a, alu_b  out  WIDTH  muxed operands (combinational from sel)
- alu_fn  out  4  muxed function (combinational from sel)
- alu_start  out  1  one-cycle pulse, first BUSY cycle
- alu_result  in  WIDTH  ALU output
- gnt  out  2  one-hot grant, held through BUSY and DONE
- done  out  2  one-cycle pulse to the served port
- result  out  WIDTH  captured ALU result; holds until next capture

## Operation

- States: IDLE, BUSY, DONE. Down-counter cnt, $clog2(LAT) bits minimum 1. Pointer last = last port served.
- IDLE: with req == 0, stay. With one req bit set, grant it. With both set, grant the port != last. On grant: sel and gnt set, last updated, cnt = LAT-1, alu_start = 1 next cycle, go BUSY.
- BUSY:
  - cnt != 0: decrement.
  - cnt == 0: result <= alu_result, done[sel] <= 1, go DONE.
  - req changes during BUSY are ignored. A dropped req still completes and still receives done.
- DONE: done clears, gnt clears, go IDLE. sel keeps its value (no glitch on mux select).
- Operand and function inputs of the granted port must be stable from grant until done.
- Reset values: state IDLE, sel 0, gnt 00, done 00, alu_start 0, result 0, cnt 0, last 1 (port 0 wins the first tie).

## Timing

- Req sampled at edge E0 in IDLE → gnt/sel valid after E0; alu_start high for the cycle E0→E1.
- done high for the cycle after edge E_LAT (LAT cycles after grant). result is valid in that same cycle.
- alu_result must be valid LAT cycles after sel changes.
- Throughput: one operation per LAT+2 cycles. A back-to-back request is re-sampled in the IDLE cycle following DONE.
- A requester that keeps req high through its done cycle is treated as a new request. Round-robin then favours the other port if it is requesting.
- LAT = 1: BUSY lasts exactly one cycle.
- Async reset mid-operation: immediate return to reset values. No done is issued for the aborted operation; last returns to 1.

## Test plan

- Single request, LAT=2: req=01, a0=5, b0=7, fn0=ADD, ALU model returns a+b after 2 cycles → gnt=01 after E0, alu_start one cycle, done=01 after E2, result=12, gnt=00 after E3.
- Tie after reset: req=11 in one cycle → port 0 served first (done=01). Port 1 is granted in the IDLE cycle after DONE (done=10). sel sequence 0 then 1.
- Sustained contention: req=11 held for 6 operations → grants strictly alternate 0,1,0,1,0,1, and a new operation starts every LAT+2 = 4 cycles.
- Request dropped mid-BUSY: req0 deasserted one cycle after grant → operation still completes, done=01 with correct result, then the block idles.
- Reset mid-BUSY: rst_n low one cycle after grant → gnt=00, done never pulses, result=0. After release, req=11 grants port 0.
- LAT=1 build: req=10, a1=9, b1=4, fn1=SUB → done=10 one cycle after grant, result=5; the full operation takes 3 cycles, IDLE to IDLE.

Source files
------------

// File: rtl/alu_port_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared ALU: grants one
// requester, holds the operand mux for LAT cycles, captures the result and pulses done.
module alu_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [3:0]       fn0,
    input  logic [3:0]       fn1,
    output logic             sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_fn,
    output logic             alu_start,
    input  logic [WIDTH-1:0] alu_result,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             last_q;
    logic             sel_q;
    logic [1:0]       gnt_q;
    logic [1:0]       done_q;
    logic             start_q;
    logic [WIDTH-1:0] result_q;

    logic             win_d;
    logic [1:0]       win_onehot_d;

    // On a tie the port that was not served last wins; otherwise the lone requester.
    always_comb begin
        win_d        = (req == 2'b11) ? ~last_q : req[1];
        win_onehot_d = win_d ? 2'b10 : 2'b01;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            start_q  <= 1'b0;
            result_q <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        sel_q   <= win_d;
                        gnt_q   <= win_onehot_d;
                        last_q  <= win_d;
                        cnt_q   <= CW'(LAT - 1);
                        start_q <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        result_q <= alu_result;
                        done_q   <= sel_q ? 2'b10 : 2'b01;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    // sel is left alone so the mux select never glitches between ops.
                    gnt_q   <= 2'b00;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign done      = done_q;
    assign alu_start = start_q;
    assign result    = result_q;

    assign alu_a  = sel_q ? a1  : a0;
    assign alu_b  = sel_q ? b1  : b0;
    assign alu_fn = sel_q ? fn1 : fn0;

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Directed bench for alu_port_arbiter: a LAT=2 instance for the main scenarios
// and a LAT=1 instance for the single-cycle BUSY case.
module tb_alu_port_arbiter;

    localparam int WIDTH = 32;
    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0]       req_l1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [3:0]       fn0, fn1;

    logic             sel, alu_start;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result, result;
    logic [3:0]       alu_fn;
    logic [1:0]       gnt, done;

    logic             sel_l1, alu_start_l1;
    logic [WIDTH-1:0] alu_a_l1, alu_b_l1, alu_result_l1, result_l1;
    logic [3:0]       alu_fn_l1;
    logic [1:0]       gnt_l1, done_l1;

    int checks   = 0;
    int failures = 0;

    function automatic logic [WIDTH-1:0] alu_model(input logic [3:0] fn,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (fn)
            FN_ADD:  return a + b;
            FN_SUB:  return a - b;
            default: return a ^ b;
        endcase
    endfunction

    // Operands are held stable for the whole operation, so a combinational
    // model presents the right value at the capture edge.
    assign alu_result    = alu_model(alu_fn, alu_a, alu_b);
    assign alu_result_l1 = alu_model(alu_fn_l1, alu_a_l1, alu_b_l1);

    alu_port_arbiter #(.WIDTH(WIDTH), .LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .fn0(fn0), .fn1(fn1),
        .sel(sel), .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
        .alu_start(alu_start), .alu_result(alu_result),
        .gnt(gnt), .done(done), .result(result)
    );

    alu_port_arbiter #(.WIDTH(WIDTH), .LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .req(req_l1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .fn0(fn0), .fn1(fn1),
        .sel(sel_l1), .alu_a(alu_a_l1), .alu_b(alu_b_l1), .alu_fn(alu_fn_l1),
        .alu_start(alu_start_l1), .alu_result(alu_result_l1),
        .gnt(gnt_l1), .done(done_l1), .result(result_l1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b00; req_l1 = 2'b00;
        a0 = 32'd5; b0 = 32'd7; fn0 = FN_ADD;
        a1 = 32'd9; b1 = 32'd4; fn1 = FN_SUB;
        step(); step();
        checks++;
        if ({sel, gnt, done, alu_start} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: sel/gnt/done/start got %b want 000000", {sel, gnt, done, alu_start});
        end
        checks++;
        if (result !== '0) begin
            failures++;
            $display("FAIL reset_result: got %0d want 0", result);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        req = 2'b01;
        step(); // E0
        checks++;
        if (gnt !== 2'b01 || sel !== 1'b0 || alu_start !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: gnt=%b sel=%b start=%b want 01 0 1", gnt, sel, alu_start);
        end
        step(); // E1
        checks++;
        if (alu_start !== 1'b0 || done !== 2'b00) begin
            failures++;
            $display("FAIL single_busy: start=%b done=%b want 0 00", alu_start, done);
        end
        step(); // E2
        checks++;
        if (done !== 2'b01 || result !== 32'd12) begin
            failures++;
            $display("FAIL single_done: done=%b result=%0d want 01 12", done, result);
        end
        req = 2'b00;
        step(); // E3
        checks++;
        if (gnt !== 2'b00 || done !== 2'b00) begin
            failures++;
            $display("FAIL single_release: gnt=%b done=%b want 00 00", gnt, done);
        end
        step();
        checks++;
        if (gnt !== 2'b00 || alu_start !== 1'b0 || result !== 32'd12) begin
            failures++;
            $display("FAIL single_idle: gnt=%b start=%b result=%0d want 00 0 12", gnt, alu_start, result);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        req = 2'b11;
        step();
        checks++;
        if (gnt !== 2'b01 || sel !== 1'b0) begin
            failures++;
            $display("FAIL tie_first: gnt=%b sel=%b want 01 0", gnt, sel);
        end
        step(); step();
        checks++;
        if (done !== 2'b01 || result !== 32'd12) begin
            failures++;
            $display("FAIL tie_done0: done=%b result=%0d want 01 12", done, result);
        end
        req = 2'b10;
        step();
        checks++;
        if (gnt !== 2'b00 || sel !== 1'b0) begin
            failures++;
            $display("FAIL tie_gap: gnt=%b sel=%b want 00 0", gnt, sel);
        end
        step();
        checks++;
        if (gnt !== 2'b10 || sel !== 1'b1 || alu_start !== 1'b1 || alu_a !== 32'd9) begin
            failures++;
            $display("FAIL tie_second: gnt=%b sel=%b start=%b alu_a=%0d want 10 1 1 9", gnt, sel, alu_start, alu_a);
        end
        step(); step();
        checks++;
        if (done !== 2'b10 || result !== 32'd5) begin
            failures++;
            $display("FAIL tie_done1: done=%b result=%0d want 10 5", done, result);
        end
        req = 2'b00;
        step();
        checks++;
        if (gnt !== 2'b00 || sel !== 1'b1) begin
            failures++;
            $display("FAIL tie_sel_hold: gnt=%b sel=%b want 00 1", gnt, sel);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]       exp_gnt;
        logic [WIDTH-1:0] exp_res;
        apply_reset();
        req = 2'b11;
        for (int op = 0; op < 6; op++) begin
            exp_gnt = (op % 2 == 0) ? 2'b01 : 2'b10;
            exp_res = (op % 2 == 0) ? 32'd12 : 32'd5;
            step(); // grant edge, every 4 cycles
            checks++;
            if (gnt !== exp_gnt || alu_start !== 1'b1) begin
                failures++;
                $display("FAIL b2b_grant op%0d: gnt=%b start=%b want %b 1", op, gnt, alu_start, exp_gnt);
            end
            step(); step();
            checks++;
            if (done !== exp_gnt || result !== exp_res) begin
                failures++;
                $display("FAIL b2b_done op%0d: done=%b result=%0d want %b %0d", op, done, result, exp_gnt, exp_res);
            end
            if (op == 5) req = 2'b00;
            step();
            checks++;
            if (gnt !== 2'b00 || done !== 2'b00) begin
                failures++;
                $display("FAIL b2b_gap op%0d: gnt=%b done=%b want 00 00", op, gnt, done);
            end
        end
        step();
        checks++;
        if (gnt !== 2'b00) begin
            failures++;
            $display("FAIL b2b_end: gnt=%b want 00", gnt);
        end
    endtask

    task automatic test_drop();
        req = 2'b01;
        step();
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL drop_grant: gnt=%b want 01", gnt);
        end
        req = 2'b00;
        step(); step();
        checks++;
        if (done !== 2'b01 || result !== 32'd12) begin
            failures++;
            $display("FAIL drop_done: done=%b result=%0d want 01 12", done, result);
        end
        step(); step();
        checks++;
        if (gnt !== 2'b00 || done !== 2'b00 || alu_start !== 1'b0) begin
            failures++;
            $display("FAIL drop_idle: gnt=%b done=%b start=%b want 00 00 0", gnt, done, alu_start);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] seen_done;
        req = 2'b10;
        step();
        checks++;
        if (gnt !== 2'b10) begin
            failures++;
            $display("FAIL rstmid_grant: gnt=%b want 10", gnt);
        end
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b00 || done !== 2'b00 || result !== '0 || sel !== 1'b0 || alu_start !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear: gnt=%b done=%b result=%0d sel=%b start=%b want 00 00 0 0 0",
                     gnt, done, result, sel, alu_start);
        end
        seen_done = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            seen_done = seen_done | done;
        end
        req = 2'b11;
        rst_n = 1'b1;
        step();
        seen_done = seen_done | done;
        checks++;
        if (seen_done !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_no_done: saw done=%b want 00", seen_done);
        end
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_tie: gnt=%b want 01", gnt);
        end
        req = 2'b00;
        step(); step(); step();
    endtask

    task automatic test_lat1();
        req_l1 = 2'b10;
        step();
        checks++;
        if (gnt_l1 !== 2'b10 || sel_l1 !== 1'b1 || alu_start_l1 !== 1'b1) begin
            failures++;
            $display("FAIL lat1_grant: gnt=%b sel=%b start=%b want 10 1 1", gnt_l1, sel_l1, alu_start_l1);
        end
        step();
        checks++;
        if (done_l1 !== 2'b10 || result_l1 !== 32'd5 || alu_start_l1 !== 1'b0) begin
            failures++;
            $display("FAIL lat1_done: done=%b result=%0d start=%b want 10 5 0", done_l1, result_l1, alu_start_l1);
        end
        req_l1 = 2'b00;
        step();
        checks++;
        if (gnt_l1 !== 2'b00 || done_l1 !== 2'b00) begin
            failures++;
            $display("FAIL lat1_idle: gnt=%b done=%b want 00 00", gnt_l1, done_l1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_lat1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
